// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard.
//   RegAddrBus : architectural register address width
//   RegBus     : architectural data width
//   RobTagBus  : default ROB tag width
//   ZeroWorld  : all-zero data word
//   Writeable  : write-enable asserted value
//   CountW     : width of the busy-register counter
package reg_scoreboard_pkg;

    localparam int unsigned RegAddrBus = 5;
    localparam int unsigned RegBus     = 32;
    localparam int unsigned RobTagBus  = 4;
    localparam int unsigned CountW     = 6;

    localparam logic [RegBus-1:0] ZeroWorld = '0;
    localparam logic              Writeable = 1'b1;

endpackage

// File: rtl/reg_scoreboard_wstage.sv
// Registered commit-to-regfile write stage.
// Ports:
//   clk_in, rst_in : clock, asynchronous active-low reset
//   load           : a commit is presented this cycle
//   load_addr      : committed destination register
//   load_data      : committed result
//   we, waddr, wdata : regfile write port, valid the cycle after load
module reg_scoreboard_wstage
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN = RegBus
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  load,
    input  logic [RegAddrBus-1:0] load_addr,
    input  logic [XLEN-1:0]       load_data,
    output logic                  we,
    output logic [RegAddrBus-1:0] waddr,
    output logic [XLEN-1:0]       wdata
);

    logic                  we_q;
    logic [RegAddrBus-1:0] waddr_q;
    logic [XLEN-1:0]       wdata_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= XLEN'(ZeroWorld);
        end else begin
            // x0 writes are dropped here so the enable is a single pulse per real write
            we_q <= (load && (load_addr != '0)) ? Writeable : ~Writeable;
            if (load) begin
                waddr_q <= load_addr;
                wdata_q <= load_data;
            end
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register-status scoreboard: tracks per-register pending results and the
// producing ROB tag, and sequences committed results onto the regfile port.
// Ports:
//   clk_in, rst_in          : clock, asynchronous active-low reset
//   issue_valid/rd/tag      : destination rename at issue
//   commit_valid/rd/tag/data: ROB head commit
//   flush_in                : clears all pending state
//   rs1/rs2_addr -> busy/tag: combinational source lookups
//   rf_we/rf_waddr/rf_wdata : regfile write port (one registered stage)
//   busy_count              : number of registers currently busy
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int unsigned TAG_W = RobTagBus,
    parameter int unsigned XLEN  = RegBus,
    parameter int unsigned NREG  = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  issue_valid,
    input  logic [RegAddrBus-1:0] issue_rd,
    input  logic [TAG_W-1:0]      issue_tag,
    input  logic                  commit_valid,
    input  logic [RegAddrBus-1:0] commit_rd,
    input  logic [TAG_W-1:0]      commit_tag,
    input  logic [XLEN-1:0]       commit_data,
    input  logic                  flush_in,
    input  logic [RegAddrBus-1:0] rs1_addr,
    input  logic [RegAddrBus-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic [TAG_W-1:0]      rs1_tag,
    output logic [TAG_W-1:0]      rs2_tag,
    output logic                  rf_we,
    output logic [RegAddrBus-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic [CountW-1:0]     busy_count
);

    logic [NREG-1:0]             busy_q, busy_d;
    logic [NREG-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [CountW-1:0]           count_q, count_d;
    logic                        issue_en, commit_clr, inc, dec;

    always_comb begin
        busy_d  = busy_q;
        tag_d   = tag_q;
        count_d = count_q;

        issue_en   = issue_valid && (issue_rd != '0) && !flush_in;
        commit_clr = commit_valid && busy_q[commit_rd] && (tag_q[commit_rd] == commit_tag);

        // A clear on the register being re-issued is overridden by the issue.
        inc = issue_en && !busy_q[issue_rd];
        dec = commit_clr && !(issue_en && (issue_rd == commit_rd));

        if (flush_in) begin
            // Tags are left stale; lookups mask them while busy is clear.
            busy_d  = '0;
            count_d = '0;
        end else begin
            if (commit_clr) begin
                busy_d[commit_rd] = 1'b0;
            end
            if (issue_en) begin
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_tag;
            end
            if (inc && !dec) begin
                count_d = count_q + CountW'(1);
            end else if (dec && !inc) begin
                count_d = count_q - CountW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q  <= '0;
            tag_q   <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            tag_q   <= tag_d;
            count_q <= count_d;
        end
    end

    // Lookups read registered state only; no same-cycle commit bypass.
    always_comb begin
        rs1_busy = (rs1_addr != '0) && busy_q[rs1_addr];
        rs2_busy = (rs2_addr != '0) && busy_q[rs2_addr];
        rs1_tag  = rs1_busy ? tag_q[rs1_addr] : '0;
        rs2_tag  = rs2_busy ? tag_q[rs2_addr] : '0;
    end

    assign busy_count = count_q;

    // Committed values are architectural, so flush does not block the load.
    reg_scoreboard_wstage #(
        .XLEN (XLEN)
    ) u_wstage (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .load      (commit_valid),
        .load_addr (commit_rd),
        .load_data (commit_data),
        .we        (rf_we),
        .waddr     (rf_waddr),
        .wdata     (rf_wdata)
    );

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [3:0]  issue_tag = '0;
    logic        commit_valid = 1'b0;
    logic [4:0]  commit_rd = '0;
    logic [3:0]  commit_tag = '0;
    logic [31:0] commit_data = '0;
    logic        flush_in = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic        rs1_busy, rs2_busy;
    logic [3:0]  rs1_tag, rs2_tag;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [5:0]  busy_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];

    reg_scoreboard #(
        .TAG_W (4),
        .XLEN  (32),
        .NREG  (32)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_tag    (issue_tag),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data),
        .flush_in     (flush_in),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_busy     (rs1_busy),
        .rs2_busy     (rs2_busy),
        .rs1_tag      (rs1_tag),
        .rs2_tag      (rs2_tag),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .busy_count   (busy_count)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every regfile write must match the oldest expected commit.
    always @(negedge clk_in) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                         rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(rf_waddr), 32'(e.addr));
                check("wr_data", rf_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        flush_in     = 1'b0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic [3:0] tg);
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_tag   = tg;
    endtask

    task automatic set_commit(input logic [4:0] rd, input logic [3:0] tg, input logic [31:0] d,
                              input bit expect_write);
        wr_t e;
        commit_valid = 1'b1;
        commit_rd    = rd;
        commit_tag   = tg;
        commit_data  = d;
        if (expect_write) begin
            e.addr = rd;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk_in);
        rs1_addr = 5'd5;
        #1;
        check("rst_rs1_busy", 32'(rs1_busy), 0);
        check("rst_rs1_tag", 32'(rs1_tag), 0);
        check("rst_rf_we", 32'(rf_we), 0);
        check("rst_rf_waddr", 32'(rf_waddr), 0);
        check("rst_rf_wdata", rf_wdata, 0);
        check("rst_count", 32'(busy_count), 0);
        tick();
        rst_in = 1'b1;

        // Issue rd=5 tag=3
        set_issue(5'd5, 4'd3);
        tick();
        idle_inputs();
        @(negedge clk_in);
        check("iss5_busy", 32'(rs1_busy), 1);
        check("iss5_tag", 32'(rs1_tag), 3);
        check("iss5_count", 32'(busy_count), 1);

        // Commit rd=5 tag=3: write next cycle, busy clears
        tick();
        set_commit(5'd5, 4'd3, 32'hDEADBEEF, 1'b1);
        check("c5_nobypass_busy", 32'(rs1_busy), 1);
        tick();
        idle_inputs();
        @(negedge clk_in);
        check("c5_rf_we", 32'(rf_we), 1);
        check("c5_busy", 32'(rs1_busy), 0);
        check("c5_count", 32'(busy_count), 0);

        // Younger rename survives an older commit
        tick();
        set_issue(5'd7, 4'd1);
        tick();
        set_issue(5'd7, 4'd2);
        tick();
        idle_inputs();
        set_commit(5'd7, 4'd1, 32'h0000_0707, 1'b1);
        tick();
        idle_inputs();
        rs1_addr = 5'd7;
        @(negedge clk_in);
        check("r7_busy", 32'(rs1_busy), 1);
        check("r7_tag", 32'(rs1_tag), 2);
        check("r7_count", 32'(busy_count), 1);

        // Same-cycle issue and commit on rd=9: issue wins
        tick();
        set_issue(5'd9, 4'd2);
        tick();
        idle_inputs();
        rs2_addr = 5'd9;
        #1;
        check("r9_pre_count", 32'(busy_count), 2);
        set_issue(5'd9, 4'd4);
        set_commit(5'd9, 4'd2, 32'h0000_0909, 1'b1);
        tick();
        idle_inputs();
        @(negedge clk_in);
        check("r9_busy", 32'(rs2_busy), 1);
        check("r9_tag", 32'(rs2_tag), 4);
        check("r9_count", 32'(busy_count), 2);

        // x0: issue and commit both ignored
        tick();
        set_issue(5'd0, 4'd5);
        set_commit(5'd0, 4'd0, 32'h55, 1'b0);
        rs1_addr = 5'd0;
        tick();
        idle_inputs();
        @(negedge clk_in);
        check("x0_busy", 32'(rs1_busy), 0);
        check("x0_tag", 32'(rs1_tag), 0);
        check("x0_rf_we", 32'(rf_we), 0);
        check("x0_count", 32'(busy_count), 2);

        // Back-to-back commits clear x7 and x9, two writes without a bubble
        tick();
        set_commit(5'd7, 4'd2, 32'hAAAA_0007, 1'b1);
        tick();
        set_commit(5'd9, 4'd4, 32'hBBBB_0009, 1'b1);
        @(negedge clk_in);
        check("b2b_first_we", 32'(rf_we), 1);
        tick();
        idle_inputs();
        @(negedge clk_in);
        check("b2b_second_we", 32'(rf_we), 1);
        check("b2b_count", 32'(busy_count), 0);
        rs1_addr = 5'd7;
        #1;
        check("b2b_r7_busy", 32'(rs1_busy), 0);
        check("b2b_r9_busy", 32'(rs2_busy), 0);

        // Three busy, then flush with a commit and a dropped issue
        tick();
        set_issue(5'd3, 4'd1);
        tick();
        set_issue(5'd4, 4'd2);
        tick();
        set_issue(5'd6, 4'd3);
        tick();
        idle_inputs();
        check("pre_flush_count", 32'(busy_count), 3);
        flush_in = 1'b1;
        set_issue(5'd10, 4'd5);
        set_commit(5'd3, 4'd1, 32'h11, 1'b1);
        rs1_addr = 5'd4;
        rs2_addr = 5'd10;
        tick();
        idle_inputs();
        @(negedge clk_in);
        check("fl_rf_we", 32'(rf_we), 1);
        check("fl_count", 32'(busy_count), 0);
        check("fl_r4_busy", 32'(rs1_busy), 0);
        check("fl_r10_busy", 32'(rs2_busy), 0);

        // Mid-operation reset discards the pending write
        tick();
        set_issue(5'd12, 4'd6);
        tick();
        idle_inputs();
        set_commit(5'd13, 4'd0, 32'h77, 1'b0);
        rs1_addr = 5'd12;
        tick();
        idle_inputs();
        rst_in = 1'b0;
        #1;
        check("mrst_rf_we", 32'(rf_we), 0);
        check("mrst_busy", 32'(rs1_busy), 0);
        check("mrst_count", 32'(busy_count), 0);
        @(negedge clk_in);
        tick();
        rst_in = 1'b1;
        tick();
        tick();

        check("writes_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
